// File: rtl/wb_stage.sv
// Writeback stage: holds one MEM/WB entry, aligns and extends load data at
// capture time, drives the register-file write port, flags misaligned loads,
// exposes a forwarding bus and counts retired instructions.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [XLEN-1:0]  in_mem_rdata,
  input  logic [2:0]       in_funct3,
  input  logic             hold,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  rd_data,
  output logic             wen,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             exc_valid,
  output logic [XLEN-1:0]  exc_addr,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;

  // Extract and extend the addressed byte/halfword; unknown load types act as LW.
  function automatic logic [31:0] align_load(input logic [2:0]  funct3,
                                             input logic [1:0]  lane,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Misalignment is only defined for the explicit halfword and word loads.
  function automatic logic misaligned(input logic [2:0] funct3,
                                      input logic [1:0] lane);
    logic m;
    case (funct3)
      3'b001, 3'b101: m = lane[0];
      3'b010:         m = (lane != 2'b00);
      default:        m = 1'b0;
    endcase
    return m;
  endfunction

  logic             wb_valid_r;
  logic [4:0]       rd_r;
  logic [XLEN-1:0]  data_r;
  logic             reg_write_r;
  logic             exc_r;
  logic [XLEN-1:0]  addr_r;
  logic [CNT_W-1:0] instret_r;

  logic             accept_s;
  logic             commit_s;
  logic             writes_rd_s;
  logic [XLEN-1:0]  cap_data_s;
  logic             cap_exc_s;

  assign in_ready    = ~wb_valid_r | ~hold;
  assign accept_s    = in_valid & in_ready;
  assign commit_s    = wb_valid_r & ~hold;
  assign writes_rd_s = wb_valid_r & reg_write_r & (rd_r != 5'd0) & ~exc_r;

  // Select the final writeback value and exception flag for the incoming entry.
  always_comb begin
    cap_data_s = in_alu_result;
    cap_exc_s  = 1'b0;
    case (in_wb_sel)
      SEL_LOAD: begin
        cap_data_s = align_load(in_funct3, in_alu_result[1:0], in_mem_rdata);
        cap_exc_s  = misaligned(in_funct3, in_alu_result[1:0]);
      end
      SEL_PC4: begin
        cap_data_s = in_pc_plus4;
        cap_exc_s  = 1'b0;
      end
      default: begin
        cap_data_s = in_alu_result;
        cap_exc_s  = 1'b0;
      end
    endcase
  end

  // Entry register: capture on handshake, otherwise drain on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_r  <= 1'b0;
      rd_r        <= 5'd0;
      data_r      <= '0;
      reg_write_r <= 1'b0;
      exc_r       <= 1'b0;
      addr_r      <= '0;
    end else if (accept_s) begin
      wb_valid_r  <= 1'b1;
      rd_r        <= in_rd;
      data_r      <= cap_data_s;
      reg_write_r <= in_reg_write;
      exc_r       <= cap_exc_s;
      addr_r      <= in_alu_result;
    end else if (commit_s) begin
      wb_valid_r  <= 1'b0;
    end
  end

  // Retired-instruction counter; faulting loads do not retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= '0;
    end else if (commit_s && !exc_r) begin
      instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rd        = rd_r;
  assign rd_data   = data_r;
  assign wen       = writes_rd_s & ~hold;
  assign fwd_valid = writes_rd_s;
  assign fwd_rd    = rd_r;
  assign fwd_data  = data_r;
  assign exc_valid = commit_s & exc_r;
  assign exc_addr  = addr_r;
  assign instret   = instret_r;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected register writes,
// scenario tasks for loads, misalignment, streaming, hold and reset.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_mem_rdata;
  logic [2:0]  in_funct3;
  logic        hold;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic        wen;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        exc_valid;
  logic [31:0] exc_addr;
  logic [63:0] instret;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [63:0] exp_instret;
  int          checks;
  int          errors;

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_mem_rdata(in_mem_rdata), .in_funct3(in_funct3), .hold(hold),
    .rd(rd), .rd_data(rd_data), .wen(wen),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .exc_valid(exc_valid), .exc_addr(exc_addr), .instret(instret)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_entry(input logic [4:0] r, input logic rw, input logic [1:0] sel,
                           input logic [31:0] alu, input logic [31:0] pc4,
                           input logic [31:0] mdata, input logic [2:0] f3);
    in_valid = 1'b1; in_rd = r; in_reg_write = rw; in_wb_sel = sel;
    in_alu_result = alu; in_pc_plus4 = pc4; in_mem_rdata = mdata; in_funct3 = f3;
  endtask

  task automatic push_write(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.rd = r; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0;
    set_entry(5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 3'b000);
    in_valid = 1'b0;
    exp_instret = 64'd0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (wen !== 1'b0 || fwd_valid !== 1'b0 || exc_valid !== 1'b0) begin errors++; $display("FAIL reset_flags: got wen=%b fwd=%b exc=%b expected 0", wen, fwd_valid, exc_valid); end
    checks++; if (rd !== 5'd0 || rd_data !== 32'd0 || exc_addr !== 32'd0) begin errors++; $display("FAIL reset_fields: got rd=%0d data=%h addr=%h expected 0", rd, rd_data, exc_addr); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (wen !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL post_reset: got wen=%b ready=%b expected 0/1", wen, in_ready); end
  endtask

  task automatic test_lb;
    wr_t e;
    @(posedge clk); #1;
    set_entry(5'd5, 1'b1, 2'd1, 32'h1003, 32'h0, 32'h80FF1234, 3'b000);
    push_write(5'd5, 32'hFFFFFF80);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wen !== 1'b1 || exp_q.size() == 0) begin
      errors++; $display("FAIL lb_wen: got %b expected 1", wen);
    end else begin
      e = exp_q.pop_front();
      if (rd !== e.rd || rd_data !== e.data) begin errors++; $display("FAIL lb_write: got rd=%0d data=%h expected rd=%0d data=%h", rd, rd_data, e.rd, e.data); end
    end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL lb_instret_before: got %0d expected %0d", instret, exp_instret); end
    exp_instret++;
    @(negedge clk);
    checks++; if (wen !== 1'b0 || instret !== exp_instret) begin errors++; $display("FAIL lb_after: got wen=%b instret=%0d expected 0/%0d", wen, instret, exp_instret); end
  endtask

  task automatic test_loads;
    logic [2:0]  t_f3   [4] = '{3'b101, 3'b001, 3'b100, 3'b011};
    logic [31:0] t_addr [4] = '{32'h2002, 32'h2002, 32'h1001, 32'h4000};
    logic [31:0] t_mem  [4] = '{32'hBEEF0001, 32'hBEEF0001, 32'h0000C300, 32'hCAFEF00D};
    logic [31:0] t_exp  [4] = '{32'h0000BEEF, 32'hFFFFBEEF, 32'h000000C3, 32'hCAFEF00D};
    wr_t e;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        set_entry(5'(10 + k), 1'b1, 2'd1, t_addr[k], 32'h0, t_mem[k], t_f3[k]);
        push_write(5'(10 + k), t_exp[k]);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (wen !== 1'b1 || exp_q.size() == 0) begin
          errors++; $display("FAIL load_wen[%0d]: got %b expected 1", k - 1, wen);
        end else begin
          e = exp_q.pop_front();
          if (rd !== e.rd || rd_data !== e.data) begin errors++; $display("FAIL load_write[%0d]: got rd=%0d data=%h expected rd=%0d data=%h", k - 1, rd, rd_data, e.rd, e.data); end
        end
      end
    end
    exp_instret += 64'd4;
    @(negedge clk);
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL load_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_misaligned;
    @(posedge clk); #1;
    set_entry(5'd7, 1'b1, 2'd1, 32'h3001, 32'h0, 32'h12345678, 3'b010);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (exc_valid !== 1'b1) begin errors++; $display("FAIL mis_exc_valid: got %b expected 1", exc_valid); end
    checks++; if (exc_addr !== 32'h3001) begin errors++; $display("FAIL mis_exc_addr: got %h expected 00003001", exc_addr); end
    checks++; if (wen !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL mis_no_write: got wen=%b fwd=%b expected 0/0", wen, fwd_valid); end
    @(negedge clk);
    checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b expected 0", exc_valid); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL mis_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_back_to_back;
    logic [4:0] t_rd [4] = '{5'd1, 5'd2, 5'd0, 5'd3};
    wr_t e;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        set_entry(t_rd[k], 1'b1, 2'd0, 32'h1100 + 32'(k), 32'h0, 32'h0, 3'b000);
        if (t_rd[k] != 5'd0) push_write(t_rd[k], 32'h1100 + 32'(k));
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (t_rd[k - 1] == 5'd0) begin
          if (wen !== 1'b0) begin errors++; $display("FAIL b2b_x0[%0d]: got wen=%b expected 0", k - 1, wen); end
        end else if (wen !== 1'b1 || exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_wen[%0d]: got %b expected 1", k - 1, wen);
        end else begin
          e = exp_q.pop_front();
          if (rd !== e.rd || rd_data !== e.data) begin errors++; $display("FAIL b2b_write[%0d]: got rd=%0d data=%h expected rd=%0d data=%h", k - 1, rd, rd_data, e.rd, e.data); end
        end
      end
    end
    exp_instret += 64'd4;
    @(negedge clk);
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL b2b_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_hold;
    wr_t e;
    @(posedge clk); #1;
    set_entry(5'd1, 1'b1, 2'd2, 32'hDEAD0000, 32'h104, 32'h0, 3'b000);
    push_write(5'd1, 32'h104);
    @(posedge clk); #1; in_valid = 1'b0; hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0 || wen !== 1'b0) begin errors++; $display("FAIL hold_freeze[%0d]: got ready=%b wen=%b expected 0/0", c, in_ready, wen); end
      checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd1 || fwd_data !== 32'h104) begin errors++; $display("FAIL hold_fwd[%0d]: got v=%b rd=%0d data=%h expected 1/1/00000104", c, fwd_valid, fwd_rd, fwd_data); end
      checks++; if (instret !== exp_instret) begin errors++; $display("FAIL hold_instret[%0d]: got %0d expected %0d", c, instret, exp_instret); end
    end
    @(posedge clk); #1; hold = 1'b0;
    @(negedge clk);
    checks++;
    if (wen !== 1'b1 || exp_q.size() == 0) begin
      errors++; $display("FAIL hold_release_wen: got %b expected 1", wen);
    end else begin
      e = exp_q.pop_front();
      if (rd !== e.rd || rd_data !== e.data) begin errors++; $display("FAIL hold_write: got rd=%0d data=%h expected rd=%0d data=%h", rd, rd_data, e.rd, e.data); end
    end
    exp_instret++;
    @(negedge clk);
    checks++; if (wen !== 1'b0 || instret !== exp_instret) begin errors++; $display("FAIL hold_after: got wen=%b instret=%0d expected 0/%0d", wen, instret, exp_instret); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    set_entry(5'd9, 1'b1, 2'd0, 32'h55, 32'h0, 32'h0, 3'b000);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (fwd_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got fwd_valid=%b expected 1", fwd_valid); end
    #1; rst_n = 1'b0;
    #1;
    exp_instret = 64'd0;
    checks++; if (wen !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_drop: got wen=%b fwd=%b expected 0/0", wen, fwd_valid); end
    checks++; if (in_ready !== 1'b1 || instret !== exp_instret || rd_data !== 32'd0) begin errors++; $display("FAIL rstmid_state: got ready=%b instret=%0d data=%h expected 1/0/0", in_ready, instret, rd_data); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (wen !== 1'b0 || instret !== exp_instret) begin errors++; $display("FAIL rstmid_after[%0d]: got wen=%b instret=%0d expected 0/0", c, wen, instret); end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lb();
    test_loads();
    test_misaligned();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32 core; sits directly upstream of the register file and drives its write port (`rd_data`, `rd`, `wen`).
- Holds one MEM/WB pipeline entry and aligns/extends load data.
- Selects the writeback source, detects misaligned loads, exposes a forwarding bus to decode/execute, and counts retired instructions.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM stage presents an entry.
- in_ready  out  1  WB stage can accept the entry this cycle.
- in_rd  in  5  destination register index.
- in_reg_write  in  1  instruction writes rd.
- in_wb_sel  in  2  source select: 0=ALU, 1=load, 2=PC+4, 3=reserved (treated as ALU).
- in_alu_result  in  32  ALU result / effective address.
- in_pc_plus4  in  32  link value.
- in_mem_rdata  in  32  raw word read from data memory.
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- hold  in  1  debug/external halt; freezes commit.
- rd  out  5  register file write index.
- rd_data  out  32  register file write data.
- wen  out  1  register file write enable.
- fwd_valid  out  1  forwarding bus carries a pending write.
- fwd_rd  out  5  forwarding index.
- fwd_data  out  32  forwarding value.
- exc_valid  out  1  misaligned-load exception pulse.
- exc_addr  out  32  faulting address.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Storage: one entry register `wb_valid` plus captured fields. Load alignment is computed at capture, so the stored value is the final writeback data.
- Acceptance:
  - in_ready = ~wb_valid | ~hold.
  - Capture occurs when in_valid & in_ready.
  - Latency is 1 cycle from capture to commit when hold=0.
- Commit:
  - The entry commits in every cycle where wb_valid & ~hold.
  - If no new entry is captured in the same cycle, wb_valid clears at the next edge.
  - Commit and capture in the same cycle are allowed, giving back-to-back throughput of 1 per cycle.
- Write port:
  - wen = wb_valid & ~hold & stored_reg_write & (stored_rd != 0) & ~stored_exc.
  - rd and rd_data are driven from the stored fields at all times.
- Load alignment:
  - Byte lane = in_alu_result[1:0].
  - LB/LBU select the byte at lane*8, then sign/zero extend.
  - LH/LHU select the halfword at lane[1]*16, then sign/zero extend.
  - LW passes the word through.
  - Undefined funct3 values with wb_sel=1 are treated as LW.
- Misaligned load:
  - Condition: wb_sel=1 and (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0).
  - The entry is captured with stored_exc=1; wen is never asserted for it.
  - exc_valid pulses high for exactly one cycle, at its commit cycle; exc_addr = stored address.
  - The entry is not counted in instret.
- Forwarding:
  - fwd_valid = wb_valid & stored_reg_write & (stored_rd != 0) & ~stored_exc.
  - fwd_valid is independent of hold, so consumers see the pending value while frozen.
- Counter: instret increments by 1 on each non-exception commit, including commits with reg_write=0. It wraps at 2^CNT_W.
- Hold:
  - While hold=1, the entry, its outputs and instret are frozen.
  - wen=0 and exc_valid=0.
  - in_ready = ~wb_valid.
- Reset (asynchronous, any time, including mid-entry): wb_valid=0, stored fields=0, instret=0.
  - Consequently wen=0, fwd_valid=0, exc_valid=0, rd=0, rd_data=0, exc_addr=0, and in_ready=1 immediately.
  - An in-flight entry is dropped without a write.

Test Plan:
- LB sign extension: capture LB, addr=0x1003, rdata=0x80FF1234, rd=5 → next cycle wen=1, rd=5, rd_data=0xFFFFFF80; instret 0→1.
- LHU / LH: LHU addr=0x2002, rdata=0xBEEF0001 → rd_data=0x0000BEEF. LH with the same inputs → rd_data=0xFFFFBEEF.
- Misaligned LW: LW addr=0x3001 → exc_valid one cycle with exc_addr=0x3001, wen=0, fwd_valid=0, instret unchanged.
- Throughput and x0 suppression: stream of 4 back-to-back ALU writes with rd=1,2,0,3 and in_valid held high → in_ready=1 throughout; wen on 4 consecutive cycles except the rd=0 cycle; instret=4.
- Hold: entry with wb_sel=2, pc_plus4=0x104, rd=1 present, then hold=1 for 3 cycles → in_ready=0, wen=0, fwd_valid=1 with fwd_data=0x104; after hold drops → wen=1 for one cycle.
- Reset mid-entry: assert rst_n=0 while wb_valid=1 → wen/fwd_valid drop asynchronously, instret=0, in_ready=1; no write occurs after release.
